store_buffer: RTL and testbench

- Parametrised store queue between the writeback stage and data memory; it replaces the single-cycle, write-only memory control of the current writeback stage.
- Accepts stores (address, data, width) over a valid/ready handshake and buffers up to DEPTH of them.
- Drains them in order to memory over a second valid/ready handshake, with lane-aligned data and byte strobes.
- Provides a load-hazard probe and flags misaligned stores.

---
 rtl/store_buffer_if.sv | 29 ++
 rtl/store_buffer.sv | 143 ++++++++++++++
 tb/tb_store_buffer.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_if.sv
// Store-buffer bus bundle: writeback-side store handshake and memory-side drain handshake.
// The slave modport is the buffer's view; master is the writeback/memory environment's view.
interface store_buffer_if #(
    parameter int unsigned XLEN = 32
) ();
    localparam int unsigned STRB_W = XLEN / 8;

    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   in_addr;
    logic [XLEN-1:0]   in_data;
    logic [1:0]        in_width;

    logic              mem_valid;
    logic              mem_ready;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;

    modport master (
        output in_valid, in_addr, in_data, in_width, mem_ready,
        input  in_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb
    );

    modport slave (
        input  in_valid, in_addr, in_data, in_width, mem_ready,
        output in_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/store_buffer.sv
// In-order store queue between writeback and data memory: lane-formats stores on entry,
// drains them over a valid/ready port, and answers load-hazard probes on aligned words.
module store_buffer #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned STRB_W = XLEN / 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    store_buffer_if.slave            bus,
    input  logic [XLEN-1:0]          probe_addr,
    output logic                     probe_hit,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     misaligned_err
);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned LANE_W = $clog2(STRB_W);
    localparam bit          DW_OK  = (XLEN == 64);

    typedef struct packed {
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   data;
        logic [STRB_W-1:0] strb;
    } entry_t;

    entry_t             entries_q [DEPTH];
    logic [PTR_W-1:0]   head_q;
    logic [PTR_W-1:0]   tail_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic               empty_q;
    logic               in_ready_q;
    logic               err_q;

    entry_t             new_entry;
    logic               illegal;
    logic               push;
    logic               push_legal;
    logic               pop;
    logic [LANE_W-1:0]  lane;
    logic [LANE_W+2:0]  shamt;
    logic [XLEN-1:0]    probe_line;
    logic [PTR_W-1:0]   slot_off;

    assign lane  = bus.in_addr[LANE_W-1:0];
    assign shamt = {lane, 3'b000};

    // Move the right-justified store value onto its byte lanes and classify alignment.
    always_comb begin
        new_entry.addr = {bus.in_addr[XLEN-1:LANE_W], LANE_W'(0)};
        new_entry.data = bus.in_data;
        new_entry.strb = '1;
        illegal        = 1'b0;
        case (bus.in_width)
            2'd0: begin
                new_entry.strb = STRB_W'(1) << lane;
                new_entry.data = XLEN'(bus.in_data[7:0]) << shamt;
            end
            2'd1: begin
                new_entry.strb = STRB_W'(2'b11) << lane;
                new_entry.data = XLEN'(bus.in_data[15:0]) << shamt;
                illegal        = lane[0];
            end
            2'd2: begin
                new_entry.strb = STRB_W'(4'hF) << lane;
                new_entry.data = XLEN'(bus.in_data[31:0]) << shamt;
                illegal        = (lane[1:0] != 2'b00);
            end
            default: begin
                illegal = (lane != '0) || !DW_OK;
            end
        endcase
    end

    // An illegal store still completes the handshake; it only skips the enqueue.
    assign push       = bus.in_valid && in_ready_q;
    assign push_legal = push && !illegal;
    assign pop        = !empty_q && bus.mem_ready;

    always_comb begin
        count_d = count_q;
        case ({push_legal, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state; in_ready/empty are registered from the next count so they never see mem_ready.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            in_ready_q <= 1'b1;
            err_q      <= 1'b0;
        end else begin
            if (pop) begin
                head_q <= head_q + PTR_W'(1);
            end
            if (push_legal) begin
                tail_q <= tail_q + PTR_W'(1);
            end
            count_q    <= count_d;
            empty_q    <= (count_d == '0);
            in_ready_q <= (count_d < CNT_W'(DEPTH));
            err_q      <= push && illegal;
        end
    end

    // Entry payloads need no reset: occupancy is tracked by head/count alone.
    always_ff @(posedge clk) begin
        if (push_legal) begin
            entries_q[tail_q] <= new_entry;
        end
    end

    // Hazard probe over occupied slots only, including the one popping this cycle.
    always_comb begin
        probe_hit  = 1'b0;
        slot_off   = '0;
        probe_line = {probe_addr[XLEN-1:LANE_W], LANE_W'(0)};
        for (int i = 0; i < int'(DEPTH); i++) begin
            slot_off = PTR_W'(i) - head_q;
            if ((CNT_W'(slot_off) < count_q) && (entries_q[i].addr == probe_line)) begin
                probe_hit = 1'b1;
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.mem_valid = !empty_q;
    assign bus.mem_addr  = entries_q[head_q].addr;
    assign bus.mem_wdata = entries_q[head_q].data;
    assign bus.mem_wstrb = entries_q[head_q].strb;

    assign count          = count_q;
    assign empty          = empty_q;
    assign misaligned_err = err_q;
endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: a byte-loop reference model queues expected memory
// writes on accepted stores; a negedge monitor compares every visible output each cycle.
module tb_store_buffer;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] probe_addr;
    logic        probe_hit;
    logic [2:0]  count;
    logic        empty;
    logic        misaligned_err;

    store_buffer_if #(.XLEN(XLEN)) bus ();

    store_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .bus            (bus),
        .probe_addr     (probe_addr),
        .probe_hit      (probe_hit),
        .count          (count),
        .empty          (empty),
        .misaligned_err (misaligned_err)
    );

    always #5 clk = ~clk;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];
    logic exp_err = 1'b0;
    bit   mon_en = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Reference formatting: walk the four byte lanes and copy the bytes the store covers.
    function automatic void model(input logic [31:0] a, input logic [31:0] d,
                                  input logic [1:0] w, output logic legal, output exp_t e);
        int size;
        int ln;
        size   = 1 << w;
        ln     = int'(a[1:0]);
        e.addr = a & ~32'h3;
        e.data = '0;
        e.strb = '0;
        legal  = (size <= 4) && ((ln % size) == 0);
        for (int b = 0; b < 4; b++) begin
            if (b >= ln && b < ln + size) begin
                e.strb[b]         = 1'b1;
                e.data[8*b +: 8]  = d[8*(b-ln) +: 8];
            end
        end
    endfunction

    function automatic logic probe_model(input logic [31:0] p);
        logic hit;
        hit = 1'b0;
        foreach (sb[i]) begin
            if (sb[i].addr == (p & ~32'h3)) hit = 1'b1;
        end
        return hit;
    endfunction

    int   sz;
    bit   accept;
    logic legal;
    exp_t e;

    // Compare pre-edge state, then advance the model by the handshakes of the coming edge.
    always @(negedge clk) begin
        if (mon_en) begin
            sz = sb.size();
            check("count",     64'(count),          64'(sz));
            check("empty",     64'(empty),          64'(sz == 0));
            check("in_ready",  64'(bus.in_ready),   64'(sz < int'(DEPTH)));
            check("mem_valid", 64'(bus.mem_valid),  64'(sz != 0));
            check("mis_err",   64'(misaligned_err), 64'(exp_err));
            check("probe_hit", 64'(probe_hit),      64'(probe_model(probe_addr)));
            if (sz != 0) begin
                check("mem_addr",  64'(bus.mem_addr),  64'(sb[0].addr));
                check("mem_wdata", 64'(bus.mem_wdata), 64'(sb[0].data));
                check("mem_wstrb", 64'(bus.mem_wstrb), 64'(sb[0].strb));
            end
            exp_err = 1'b0;
            if (!reset_n) begin
                sb.delete();
            end else begin
                accept = bus.in_valid && (sz < int'(DEPTH));
                if (sz != 0 && bus.mem_ready) void'(sb.pop_front());
                if (accept) begin
                    model(bus.in_addr, bus.in_data, bus.in_width, legal, e);
                    if (legal) sb.push_back(e);
                    else       exp_err = 1'b1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one store and hold it until accepted; returns just after the accepting edge.
    task automatic push_wait(input logic [31:0] a, input logic [31:0] d, input logic [1:0] w);
        bit done;
        done         = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_addr  = a;
        bus.in_data  = d;
        bus.in_width = w;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                step();
                done = 1'b1;
            end
        end
        bus.in_valid = 1'b0;
        if (!done) check("push_timeout", 64'(done), 64'(1));
    endtask

    task automatic drain();
        bit done;
        done          = 1'b0;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (empty) done = 1'b1;
        end
        step();
        bus.mem_ready = 1'b0;
        if (!done) check("drain_timeout", 64'(done), 64'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_addr   = '0;
        bus.in_data   = '0;
        bus.in_width  = '0;
        bus.mem_ready = 1'b0;
        probe_addr    = '0;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        step();
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_mem_valid", 64'(bus.mem_valid),  64'(0));
        check("rst_count",     64'(count),          64'(0));
        check("rst_empty",     64'(empty),          64'(1));
        check("rst_in_ready",  64'(bus.in_ready),   64'(1));
        check("rst_err",       64'(misaligned_err), 64'(0));
        step();

        // Single byte store at the top lane.
        push_wait(32'h103, 32'hAB, 2'd0);
        @(negedge clk);
        check("t1_mem_valid", 64'(bus.mem_valid), 64'(1));
        check("t1_mem_addr",  64'(bus.mem_addr),  64'h100);
        check("t1_mem_wstrb", 64'(bus.mem_wstrb), 64'h8);
        check("t1_mem_wdata", 64'(bus.mem_wdata), 64'hAB00_0000);
        check("t1_count",     64'(count),         64'(1));
        step();
        drain();

        // Fill with memory stalled; a fifth store must be refused.
        for (int i = 0; i < 4; i++) push_wait(32'h200 + 32'(4*i), 32'h1000 + 32'(i), 2'd2);
        @(negedge clk);
        check("t2_in_ready", 64'(bus.in_ready), 64'(0));
        check("t2_count",    64'(count),        64'(4));
        step();
        bus.in_valid = 1'b1;
        bus.in_addr  = 32'h210;
        bus.in_data  = 32'h2000;
        bus.in_width = 2'd2;
        repeat (3) begin
            @(negedge clk);
            check("t2_hold_ready", 64'(bus.in_ready), 64'(0));
            check("t2_hold_addr",  64'(bus.mem_addr), 64'h200);
            step();
        end

        // Drain while pushing continuously across the pointer wrap.
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) push_wait(32'h210 + 32'(4*i), 32'h2000 + 32'(i), 2'd2);
        drain();
        check("t3_sb_empty", 64'(sb.size()), 64'(0));

        // Misaligned half, aligned upper half, and doubleword on a 32-bit buffer.
        push_wait(32'h301, 32'hBEEF, 2'd1);
        @(negedge clk);
        check("t4_err",   64'(misaligned_err), 64'(1));
        check("t4_count", 64'(count),          64'(0));
        step();
        @(negedge clk);
        check("t4_err_clear", 64'(misaligned_err), 64'(0));
        step();
        push_wait(32'h302, 32'h1234, 2'd1);
        @(negedge clk);
        check("t4_wstrb", 64'(bus.mem_wstrb), 64'hC);
        check("t4_wdata", 64'(bus.mem_wdata), 64'h1234_0000);
        check("t4_addr",  64'(bus.mem_addr),  64'h300);
        step();
        push_wait(32'h500, 32'h5, 2'd3);
        @(negedge clk);
        check("t4_dw_err",   64'(misaligned_err), 64'(1));
        check("t4_dw_count", 64'(count),          64'(1));
        step();
        drain();

        // Load-hazard probe.
        push_wait(32'h400, 32'hCAFE, 2'd2);
        probe_addr = 32'h402;
        @(negedge clk);
        check("t5_hit_same", 64'(probe_hit), 64'(1));
        step();
        probe_addr = 32'h404;
        @(negedge clk);
        check("t5_hit_next", 64'(probe_hit), 64'(0));
        step();
        probe_addr    = 32'h402;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        check("t5_hit_popping", 64'(probe_hit), 64'(1));
        step();
        bus.mem_ready = 1'b0;
        @(negedge clk);
        check("t5_hit_popped", 64'(probe_hit), 64'(0));
        step();

        // Reset with entries pending and a pop in flight.
        push_wait(32'h600, 32'h1, 2'd2);
        push_wait(32'h604, 32'h2, 2'd2);
        @(negedge clk);
        check("t6_pre_count", 64'(count),         64'(2));
        check("t6_pre_valid", 64'(bus.mem_valid), 64'(1));
        step();
        reset_n       = 1'b0;
        bus.mem_ready = 1'b1;
        step();
        reset_n       = 1'b1;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        check("t6_mem_valid", 64'(bus.mem_valid), 64'(0));
        check("t6_count",     64'(count),         64'(0));
        check("t6_empty",     64'(empty),         64'(1));
        step();
        push_wait(32'h701, 32'h55, 2'd0);
        @(negedge clk);
        check("t6_addr",  64'(bus.mem_addr),  64'h700);
        check("t6_wstrb", 64'(bus.mem_wstrb), 64'h2);
        check("t6_wdata", 64'(bus.mem_wdata), 64'h5500);
        step();
        drain();
        @(negedge clk);
        check("final_empty", 64'(empty), 64'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
